// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor step per clock.
// Operands and results move over valid/ready handshakes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;

  logic             w_hd;
  logic             w_hb;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // First half-subtractor on the operand bits, second folds in the borrow.
  assign w_hd   = r_sa[0] ^ r_sb[0];
  assign w_hb   = ~r_sa[0] & r_sb[0];
  assign w_d    = w_hd ^ r_bin;
  assign w_bout = w_hb | (~w_hd & r_bin);

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_res_nxt = WIDTH'({w_d, r_res} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (in_valid) begin
            r_sa    <= a;
            r_sb    <= b;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        (r_state == S_RUN): begin
          r_res <= w_res_nxt;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_bin <= w_bout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bout;
            r_state  <= S_DONE;
          end
        end
        (r_state == S_DONE): begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8, 4 and 1.
// A per-cycle arithmetic model checks every output of every instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int W [3] = '{8, 4, 1};

  logic [2:0]  rstn;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  ordy_set;
  logic [2:0]  rnd;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  bo;
  logic [31:0] ta  [3];
  logic [31:0] tbv [3];
  logic [7:0]  d8;
  logic [3:0]  d4;
  logic        d1;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rstn[0]),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(ta[0][7:0]), .b(tbv[0][7:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .diff(d8), .borrow(bo[0])
  );

  serial_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rstn[1]),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(ta[1][3:0]), .b(tbv[1][3:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .diff(d4), .borrow(bo[1])
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rstn[2]),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(ta[2][0:0]), .b(tbv[2][0:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .diff(d1), .borrow(bo[2])
  );

  function automatic logic [31:0] dget(input int k);
    case (k)
      0:       dget = 32'(d8);
      1:       dget = 32'(d4);
      default: dget = 32'(d1);
    endcase
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (W=%0d): got 0x%0h, expected 0x%0h",
               nm, W[k], act, exp);
    end
  endtask

  // out_ready owner: either a fixed level or random stalls.
  initial begin
    ordy = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        ordy[k] = rnd[k] ? ($urandom_range(0, 2) != 0) : ordy_set[k];
    end
  end

  // Model: cycles left until the result, plus a pending-result flag.
  int          m_left [3] = '{0, 0, 0};
  bit          m_pend [3] = '{0, 0, 0};
  logic [31:0] m_diff [3] = '{0, 0, 0};
  logic [31:0] m_bor  [3] = '{0, 0, 0};
  logic [31:0] m_nd   [3] = '{0, 0, 0};
  logic [31:0] m_nb   [3] = '{0, 0, 0};
  int          accepts   [3] = '{0, 0, 0};
  int          results   [3] = '{0, 0, 0};
  int          discarded [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [31:0] mask;
      logic [31:0] av;
      logic [31:0] bv;
      bit          idle;
      mask = (32'd1 << W[k]) - 32'd1;
      if (!rstn[k]) begin
        if (m_left[k] != 0 || m_pend[k]) discarded[k]++;
        m_left[k] = 0;
        m_pend[k] = 1'b0;
        m_diff[k] = '0;
        m_bor[k]  = '0;
      end
      idle = (m_left[k] == 0) && !m_pend[k];
      chk("in_ready", k, 32'(ir[k]), 32'(idle));
      chk("out_valid", k, 32'(ov[k]), 32'(m_pend[k]));
      chk("diff", k, dget(k), m_diff[k]);
      chk("borrow", k, 32'(bo[k]), m_bor[k]);
      if (rstn[k]) begin
        if (idle) begin
          if (iv[k]) begin
            av = ta[k] & mask;
            bv = tbv[k] & mask;
            m_nd[k]   = (av - bv) & mask;
            m_nb[k]   = 32'(av < bv);
            m_left[k] = W[k];
            accepts[k]++;
          end
        end else if (m_left[k] != 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_pend[k] = 1'b1;
            m_diff[k] = m_nd[k];
            m_bor[k]  = m_nb[k];
          end
        end else if (ordy[k]) begin
          m_pend[k] = 1'b0;
          results[k]++;
        end
      end
    end
  end

  // All main-flow steps run at posedge+2.
  task automatic accept(input int k, input logic [31:0] a,
                        input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    ta[k]  = a;
    tbv[k] = b;
    iv[k]  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (ir[k]) begin
        @(posedge clk);
        #2;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    iv[k] = 1'b0;
    chk("accept_timeout", k, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input int k, output int cyc);
    cyc = 0;
    while (!ov[k] && cyc < 200) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (!ov[k]) chk("valid_timeout", k, 32'(ov[k]), 32'd1);
  endtask

  task automatic wait_ready(input int k, output int cyc);
    cyc = 0;
    while (!ir[k] && cyc < 400) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (!ir[k]) chk("ready_timeout", k, 32'(ir[k]), 32'd1);
  endtask

  task automatic run_lit(input int k, input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] ed,
                         input logic [31:0] eb,
                         input string nm);
    int cyc;
    accept(k, a, b);
    wait_valid(k, cyc);
    chk({nm, "_latency"}, k, 32'(cyc), 32'(W[k]));
    chk({nm, "_diff"}, k, dget(k), ed);
    chk({nm, "_borrow"}, k, 32'(bo[k]), eb);
    wait_ready(k, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int c2;
    rstn     = '1;
    iv       = '0;
    ordy_set = '1;
    rnd      = '0;
    for (int k = 0; k < 3; k++) begin
      ta[k]  = '0;
      tbv[k] = '0;
    end
    #1 rstn = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_in_ready", 0, 32'(ir[0]), 32'd1);
    chk("reset_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("reset_diff", 0, dget(0), 32'd0);
    rstn = '1;
    @(posedge clk);
    #2;

    // Basic subtract with latency and turnaround.
    accept(0, 32'h5A, 32'h3C);
    wait_valid(0, c1);
    chk("basic_latency", 0, 32'(c1), 32'd8);
    chk("basic_diff", 0, dget(0), 32'h1E);
    chk("basic_borrow", 0, 32'(bo[0]), 32'd0);
    wait_ready(0, c2);
    // Ready after E9, so the next accept can land on E10.
    chk("ready_return", 0, 32'(c1 + c2), 32'd9);

    run_lit(0, 32'h00, 32'h01, 32'hFF, 32'd1, "b00_01");
    run_lit(0, 32'hFF, 32'hFF, 32'h00, 32'd0, "bFF_FF");
    run_lit(0, 32'h80, 32'h7F, 32'h01, 32'd0, "b80_7F");
    run_lit(0, 32'h00, 32'hFF, 32'h01, 32'd1, "b00_FF");

    // Back-pressure with stray operand pulses.
    ordy_set[0] = 1'b0;
    @(posedge clk);
    #2;
    accept(0, 32'hC3, 32'h2A);
    ta[0]  = 32'h11;
    tbv[0] = 32'h22;
    for (int c = 1; c <= 8; c++) begin
      iv[0] = c[0];
      @(posedge clk);
      #2;
      if (c < 8) chk("bp_ready_low", 0, 32'(ir[0]), 32'd0);
    end
    chk("bp_valid", 0, 32'(ov[0]), 32'd1);
    chk("bp_diff", 0, dget(0), 32'h99);
    for (int c = 0; c < 5; c++) begin
      iv[0] = ~iv[0];
      @(posedge clk);
      #2;
      chk("bp_hold_valid", 0, 32'(ov[0]), 32'd1);
      chk("bp_hold_diff", 0, dget(0), 32'h99);
      chk("bp_hold_borrow", 0, 32'(bo[0]), 32'd0);
      chk("bp_hold_ready", 0, 32'(ir[0]), 32'd0);
    end
    iv[0] = 1'b0;
    ordy_set[0] = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_still_valid", 0, 32'(ov[0]), 32'd1);
    @(posedge clk);
    #2;
    chk("bp_release_valid", 0, 32'(ov[0]), 32'd0);
    chk("bp_release_ready", 0, 32'(ir[0]), 32'd1);
    chk("bp_idle_hold", 0, dget(0), 32'h99);

    // Asynchronous reset in the third RUN cycle.
    accept(0, 32'h37, 32'h12);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rstn[0] = 1'b0;
    #1;
    chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("rst_in_ready", 0, 32'(ir[0]), 32'd1);
    chk("rst_diff", 0, dget(0), 32'd0);
    chk("rst_borrow", 0, 32'(bo[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rstn[0] = 1'b1;
    @(posedge clk);
    #2;
    run_lit(0, 32'h10, 32'h01, 32'h0F, 32'd0, "after_rst");

    // Exhaustive WIDTH=4 with random stalls.
    rnd[1] = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        accept(1, 32'(a), 32'(b));
    rnd[1] = 1'b0;
    wait_ready(1, c1);

    // WIDTH=1 truth table.
    run_lit(2, 32'd0, 32'd0, 32'd0, 32'd0, "w1_00");
    run_lit(2, 32'd0, 32'd1, 32'd1, 32'd1, "w1_01");
    run_lit(2, 32'd1, 32'd0, 32'd1, 32'd0, "w1_10");
    run_lit(2, 32'd1, 32'd1, 32'd0, 32'd0, "w1_11");

    // Random WIDTH=8 traffic with stalls.
    rnd[0] = 1'b1;
    for (int i = 0; i < 40; i++)
      accept(0, 32'($urandom_range(0, 255)),
             32'($urandom_range(0, 255)));
    rnd[0] = 1'b0;
    wait_ready(0, c1);
    @(posedge clk);
    #2;

    for (int k = 0; k < 3; k++)
      chk("one_result_per_op", k, 32'(results[k]),
          32'(accepts[k] - discarded[k]));
    chk("exhaustive_count", 1, 32'(results[1]), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
